// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared definitions for the timer/sequencer counters: the
//               down-counter state encoding and the default counter width
//               used by both the up-counter and the countdown timer.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Default counter/load width shared by the counter family.
    localparam int C_DEFAULT_WIDTH = 4;

    // Countdown timer state encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Synchronous loadable down-counter with a one-cycle
//               terminal-count pulse and optional auto-reload.
//               Command priority on every edge: abort > start > pause > count.
// Ports       : clock       - rising-edge clock
//               reset       - asynchronous active-high reset
//               start       - load load_value and begin counting
//               abort       - stop counting, return to IDLE, clear Q
//               pause       - hold the count while in RUN
//               auto_reload - at terminal count, reload and keep running
//               load_value  - start value, sampled with start
//               Q           - current count (registered)
//               tc          - terminal-count pulse (registered)
//               busy        - high while in RUN (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             busy
);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_q_nxt;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             w_tc_nxt;
    logic             w_busy_nxt;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_q      <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_q      <= w_q_nxt;
            r_reload <= w_reload_nxt;
            r_tc     <= w_tc_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_q_nxt      = r_q;
        w_reload_nxt = r_reload;
        w_tc_nxt     = 1'b0;

        if (abort) begin
            // reload is deliberately kept across an abort
            w_state_nxt = IDLE;
            w_q_nxt     = '0;
        end else if (start) begin
            w_reload_nxt = load_value;
            if (load_value != '0) begin
                w_state_nxt = RUN;
                w_q_nxt     = load_value;
            end else begin
                // Zero load is an immediate terminal count; auto_reload
                // does not apply because we never enter RUN.
                w_state_nxt = DONE;
                w_q_nxt     = '0;
                w_tc_nxt    = 1'b1;
            end
        end else if (r_state == RUN && !pause) begin
            if (r_q != '0) begin
                // Decrement only from a non-zero count, so Q never wraps.
                w_q_nxt  = r_q - WIDTH'(1);
                w_tc_nxt = (r_q == WIDTH'(1));
            end else if (auto_reload) begin
                // Q = 0 cycle: auto_reload is sampled here, after the pulse.
                w_q_nxt = r_reload;
            end else begin
                w_state_nxt = DONE;
            end
        end

        // busy is registered from the state being entered so that it
        // changes on the same edge as the state itself.
        w_busy_nxt = (w_state_nxt == RUN);
    end

    assign Q    = r_q;
    assign tc   = r_tc;
    assign busy = r_busy;

endmodule : countdown_timer
`default_nettype wire
